// File: rtl/state_save_sequencer.sv
// Initiator for the data memory's interrupt state save/restore stack protocol.
// Saves PC and flags on interrupt entry and reloads them on return-from-interrupt.
module state_save_sequencer #(
  parameter logic [31:0] INT_VECTOR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic        rti_req,
  input  logic [31:0] pc_in,
  input  logic [15:0] bus_with_fetch,
  output logic [2:0]  save_state_counter,
  output logic [2:0]  state_type,
  output logic [31:0] saved_pc,
  output logic        stall,
  output logic        pc_load,
  output logic [31:0] pc_load_value,
  output logic        flags_load,
  output logic [2:0]  flags_restored,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    LOAD    = 2'd3
  } state_t;

  localparam logic [2:0] TYPE_NONE    = 3'd0;
  localparam logic [2:0] TYPE_SAVE    = 3'd1;
  localparam logic [2:0] TYPE_RESTORE = 3'd2;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] saved_pc_q, saved_pc_d;
  logic        stall_q, stall_d;
  logic        pc_load_q, pc_load_d;
  logic [31:0] pcv_q, pcv_d;
  logic        flags_load_q, flags_load_d;
  logic [2:0]  flags_q, flags_d;
  logic        busy_q, busy_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      type_q       <= TYPE_NONE;
      saved_pc_q   <= 32'd0;
      stall_q      <= 1'b0;
      pc_load_q    <= 1'b0;
      pcv_q        <= 32'd0;
      flags_load_q <= 1'b0;
      flags_q      <= 3'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      type_q       <= type_d;
      saved_pc_q   <= saved_pc_d;
      stall_q      <= stall_d;
      pc_load_q    <= pc_load_d;
      pcv_q        <= pcv_d;
      flags_load_q <= flags_load_d;
      flags_q      <= flags_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    type_d       = type_q;
    saved_pc_d   = saved_pc_q;
    stall_d      = stall_q;
    pc_load_d    = 1'b0;
    pcv_d        = pcv_q;
    flags_load_d = 1'b0;
    flags_d      = flags_q;
    busy_d       = busy_q;

    case (state_q)
      IDLE: begin
        if (int_req) begin
          saved_pc_d = pc_in;
          cnt_d      = 3'd3;
          type_d     = TYPE_SAVE;
          stall_d    = 1'b1;
          busy_d     = 1'b1;
          state_d    = SAVE;
        end else if (rti_req) begin
          cnt_d   = 3'd4;
          type_d  = TYPE_RESTORE;
          stall_d = 1'b1;
          busy_d  = 1'b1;
          state_d = RESTORE;
        end
      end
      SAVE: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          type_d    = TYPE_NONE;
          busy_d    = 1'b0;
          pc_load_d = 1'b1;
          pcv_d     = INT_VECTOR;
          state_d   = LOAD;
        end
      end
      RESTORE: begin
        // Memory pops flags, PC low, PC high; each word is on the bus one edge after its pop.
        cnt_d = cnt_q - 3'd1;
        case (cnt_q)
          3'd3: flags_d = bus_with_fetch[2:0];
          3'd2: pcv_d[15:0] = bus_with_fetch;
          3'd1: begin
            pcv_d[31:16] = bus_with_fetch;
            type_d       = TYPE_NONE;
            busy_d       = 1'b0;
            pc_load_d    = 1'b1;
            flags_load_d = 1'b1;
            state_d      = LOAD;
          end
          default: ;
        endcase
      end
      LOAD: begin
        // Stall spans the pc_load cycle; requests seen here are deliberately not accepted.
        stall_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign save_state_counter = cnt_q;
  assign state_type         = type_q;
  assign saved_pc           = saved_pc_q;
  assign stall              = stall_q;
  assign pc_load            = pc_load_q;
  assign pc_load_value      = pcv_q;
  assign flags_load         = flags_load_q;
  assign flags_restored     = flags_q;
  assign busy               = busy_q;

endmodule
